// File: rtl/cpu_dp_multicycle_pkg.sv
// Shared constants for the multicycle data-processing core: FSM states, ALU
// opcodes, shift types, condition codes, encoding classes and amount selects.
package cpu_dp_multicycle_pkg;

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StWb     = 3'd3;

  localparam logic [3:0] AluAnd = 4'h0;
  localparam logic [3:0] AluEor = 4'h1;
  localparam logic [3:0] AluSub = 4'h2;
  localparam logic [3:0] AluRsb = 4'h3;
  localparam logic [3:0] AluAdd = 4'h4;
  localparam logic [3:0] AluAdc = 4'h5;
  localparam logic [3:0] AluSbc = 4'h6;
  localparam logic [3:0] AluRsc = 4'h7;
  localparam logic [3:0] AluTst = 4'h8;
  localparam logic [3:0] AluTeq = 4'h9;
  localparam logic [3:0] AluCmp = 4'hA;
  localparam logic [3:0] AluCmn = 4'hB;
  localparam logic [3:0] AluOrr = 4'hC;
  localparam logic [3:0] AluMov = 4'hD;
  localparam logic [3:0] AluBic = 4'hE;
  localparam logic [3:0] AluMvn = 4'hF;

  localparam logic [1:0] ShLsl = 2'd0;
  localparam logic [1:0] ShLsr = 2'd1;
  localparam logic [1:0] ShAsr = 2'd2;
  localparam logic [1:0] ShRor = 2'd3;

  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondAl = 4'hE;

  localparam logic [1:0] ClsDp0 = 2'd0;
  localparam logic [1:0] ClsDp1 = 2'd1;
  localparam logic [1:0] ClsDp2 = 2'd2;
  localparam logic [1:0] ClsIll = 2'd3;

  // Source of the shift amount
  localparam logic [1:0] AmtImm5 = 2'd0;
  localparam logic [1:0] AmtReg  = 2'd1;
  localparam logic [1:0] AmtRot  = 2'd2;

endpackage

// File: rtl/cpu_dp_multicycle_if.sv
// Instruction-fetch bus between the core (master) and instruction memory (slave).
interface cpu_dp_multicycle_if #(
  parameter int PC_W = 8
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/cpu_dp_decode.sv
// Combinational instruction decoder: encoding class, ALU/shift ops, shift-amount
// source, register write enable and condition evaluation against NZCV.
module cpu_dp_decode
  import cpu_dp_multicycle_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [2:0] enc,
  input  logic [3:0] opcode,
  input  logic       bit7,
  input  logic       bit4,
  input  logic [1:0] sh_type,
  input  logic [3:0] nzcv,
  output logic [1:0] cls,
  output logic [3:0] alu_op,
  output logic [1:0] shift_op,
  output logic [1:0] amt_sel,
  output logic       src_imm,
  output logic       reg_we,
  output logic       cond_pass
);

  // Classify encoding and derive operand selects
  always_comb begin
    cls = ClsIll;
    if (enc == 3'b000 && !bit4)              cls = ClsDp0;
    else if (enc == 3'b000 && bit4 && !bit7) cls = ClsDp1;
    else if (enc == 3'b001)                  cls = ClsDp2;
    alu_op   = opcode;
    src_imm  = (cls == ClsDp2);
    shift_op = src_imm ? ShRor : sh_type;
    case (cls)
      ClsDp0:  amt_sel = AmtImm5;
      ClsDp1:  amt_sel = AmtReg;
      default: amt_sel = AmtRot;
    endcase
    // TST/TEQ/CMP/CMN occupy opcodes 10xx and only set flags
    reg_we = (opcode[3:2] != 2'b10);
  end

  // Condition check; unsupported codes never pass
  always_comb begin
    case (cond)
      CondEq:  cond_pass = nzcv[2];
      CondNe:  cond_pass = !nzcv[2];
      CondCs:  cond_pass = nzcv[1];
      CondCc:  cond_pass = !nzcv[1];
      CondMi:  cond_pass = nzcv[3];
      CondPl:  cond_pass = !nzcv[3];
      CondVs:  cond_pass = nzcv[0];
      CondVc:  cond_pass = !nzcv[0];
      CondAl:  cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_dp_multicycle.sv
// Four-state (fetch/decode/exec/writeback) data-processing core with a 16-entry
// register file, barrel shifter and 16-op ALU.
module cpu_dp_multicycle
  import cpu_dp_multicycle_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          PC_W   = 8,
  parameter int unsigned RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  cpu_dp_multicycle_if.master imem,
  output logic [31:0]       IR,
  output logic [PC_W-1:0]   PC,
  output logic [3:0]        NZCV,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic [DATA_W-1:0] F,
  output logic              Write_IR,
  output logic              Write_PC,
  output logic              Write_Reg,
  output logic              retire,
  output logic              illegal,
  output logic [2:0]        state
);

  logic [2:0]        state_q, state_d;
  logic [31:0]       ir_q;
  logic [PC_W-1:0]   pc_q;
  logic [3:0]        nzcv_q, flags_q, flags_d;
  logic [DATA_W-1:0] a_q, b_q, c_q, f_q, f_d;
  logic [DATA_W-1:0] regs [16];

  logic [1:0] cls, shift_op, amt_sel;
  logic [3:0] alu_op;
  logic       src_imm, reg_we, cond_pass;

  cpu_dp_decode u_decode (
    .cond      (ir_q[31:28]),
    .enc       (ir_q[27:25]),
    .opcode    (ir_q[24:21]),
    .bit7      (ir_q[7]),
    .bit4      (ir_q[4]),
    .sh_type   (ir_q[6:5]),
    .nzcv      (nzcv_q),
    .cls       (cls),
    .alu_op    (alu_op),
    .shift_op  (shift_op),
    .amt_sel   (amt_sel),
    .src_imm   (src_imm),
    .reg_we    (reg_we),
    .cond_pass (cond_pass)
  );

  logic [DATA_W-1:0]          sh_src, sh_res;
  logic                       sh_c;
  logic [7:0]                 sh_amt, rot;
  logic [2*DATA_W-1:0]        sh_ext;
  logic signed [2*DATA_W-1:0] sh_sext;

  // Barrel shifter; the double-width shifts yield the carry-out bit directly
  always_comb begin
    sh_src = src_imm ? DATA_W'(ir_q[7:0]) : b_q;
    case (amt_sel)
      AmtImm5: sh_amt = {3'b000, ir_q[11:7]};
      AmtReg:  sh_amt = c_q[7:0];
      default: sh_amt = {3'b000, ir_q[11:8], 1'b0};
    endcase
    sh_res  = sh_src;
    sh_c    = nzcv_q[1];
    sh_ext  = '0;
    sh_sext = '0;
    rot     = '0;
    if (sh_amt != 8'd0) begin
      case (shift_op)
        ShLsl: begin
          sh_ext = {{DATA_W{1'b0}}, sh_src} << sh_amt;
          sh_res = sh_ext[DATA_W-1:0];
          sh_c   = sh_ext[DATA_W];
        end
        ShLsr: begin
          sh_ext = {sh_src, {DATA_W{1'b0}}} >> sh_amt;
          sh_res = sh_ext[2*DATA_W-1:DATA_W];
          sh_c   = sh_ext[DATA_W-1];
        end
        ShAsr: begin
          sh_sext = $signed({sh_src, {DATA_W{1'b0}}}) >>> sh_amt;
          sh_res  = sh_sext[2*DATA_W-1:DATA_W];
          sh_c    = sh_sext[DATA_W-1];
        end
        default: begin
          rot    = sh_amt % 8'(DATA_W);
          sh_res = (sh_src >> rot) | (sh_src << (8'(DATA_W) - rot));
          sh_c   = sh_res[DATA_W-1];
        end
      endcase
    end
  end

  logic [DATA_W-1:0] alu_x, alu_y, alu_sum;
  logic              alu_cin, alu_cout, alu_v, arith;

  // ALU: arithmetic ops share one adder with operand inversion/swap
  always_comb begin
    alu_x   = a_q;
    alu_y   = sh_res;
    alu_cin = 1'b0;
    arith   = 1'b1;
    case (alu_op)
      AluSub, AluCmp: begin alu_y = ~sh_res; alu_cin = 1'b1; end
      AluRsb: begin alu_x = sh_res; alu_y = ~a_q; alu_cin = 1'b1; end
      AluAdd, AluCmn: alu_cin = 1'b0;
      AluAdc: alu_cin = nzcv_q[1];
      AluSbc: begin alu_y = ~sh_res; alu_cin = nzcv_q[1]; end
      AluRsc: begin alu_x = sh_res; alu_y = ~a_q; alu_cin = nzcv_q[1]; end
      default: arith = 1'b0;
    endcase
    {alu_cout, alu_sum} = {1'b0, alu_x} + {1'b0, alu_y} + {{DATA_W{1'b0}}, alu_cin};
    alu_v = (alu_x[DATA_W-1] == alu_y[DATA_W-1]) && (alu_sum[DATA_W-1] != alu_x[DATA_W-1]);
    case (alu_op)
      AluAnd, AluTst: f_d = a_q & sh_res;
      AluEor, AluTeq: f_d = a_q ^ sh_res;
      AluOrr:         f_d = a_q | sh_res;
      AluMov:         f_d = sh_res;
      AluBic:         f_d = a_q & ~sh_res;
      AluMvn:         f_d = ~sh_res;
      default:        f_d = alu_sum;
    endcase
    flags_d = {f_d[DATA_W-1], (f_d == '0), arith ? alu_cout : sh_c, arith ? alu_v : nzcv_q[0]};
  end

  // Next-state sequencing; illegal or skipped instructions return to fetch
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (imem.imem_valid) state_d = StDecode;
      StDecode: state_d = (cls == ClsIll || !cond_pass) ? StFetch : StExec;
      StExec:   state_d = StWb;
      default:  state_d = StFetch;
    endcase
  end

  // Architectural state update; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      ir_q    <= '0;
      pc_q    <= PC_W'(RST_PC);
      nzcv_q  <= '0;
      flags_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      f_q     <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StFetch: if (imem.imem_valid) begin
          ir_q <= imem.imem_rdata;
          pc_q <= pc_q + PC_W'(1);
        end
        StDecode: begin
          a_q <= regs[ir_q[19:16]];
          b_q <= regs[ir_q[3:0]];
          c_q <= regs[ir_q[11:8]];
        end
        StExec: begin
          f_q     <= f_d;
          flags_q <= flags_d;
        end
        default: begin
          if (reg_we) regs[ir_q[15:12]] <= f_q;
          if (ir_q[20]) nzcv_q <= flags_q;
        end
      endcase
    end
  end

  assign imem.imem_req  = (state_q == StFetch) && !rst;
  assign imem.imem_addr = pc_q;
  assign Write_IR  = imem.imem_req && imem.imem_valid;
  assign Write_PC  = Write_IR;
  assign Write_Reg = (state_q == StWb) && reg_we && !rst;
  assign retire    = (state_q == StWb) && !rst;
  assign illegal   = (state_q == StDecode) && (cls == ClsIll) && !rst;
  assign IR    = ir_q;
  assign PC    = pc_q;
  assign NZCV  = nzcv_q;
  assign A     = a_q;
  assign B     = b_q;
  assign C     = c_q;
  assign F     = f_q;
  assign state = state_q;

endmodule

// File: doc/cpu_dp_multicycle.md
CPU_DP_MULTICYCLE -- requirements
Module: cpu_dp_multicycle

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath and register width (legal range 16..32).
REQ-002 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-address width.
REQ-003 SHALL have parameter RST_PC, default 0, meaning the PC value loaded at reset.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port imem_req  output  1  meaning instruction-fetch request.
REQ-007 SHALL have port imem_addr  output  PC_W  meaning fetch address, equal to PC.
REQ-008 SHALL have port imem_valid  input  1  meaning imem_rdata is valid this cycle.
REQ-009 SHALL have port imem_rdata  input  32  meaning the fetched instruction word.
REQ-010 SHALL have outputs IR[31:0], PC[PC_W-1:0], NZCV[3:0], A, B, C and F[DATA_W-1:0], meaning the architectural and debug state.
REQ-011 SHALL have outputs Write_IR, Write_PC, Write_Reg, retire, illegal (1 bit each) and state[2:0].

Function
REQ-012 SHALL sequence FETCH -> DECODE -> EXEC -> WB -> FETCH.
REQ-013 FETCH SHALL hold imem_req=1 until imem_valid=1; that cycle: IR<=imem_rdata, PC<=PC+1 (wrapping modulo 2^PC_W), Write_IR=Write_PC=1, go to DECODE.
REQ-014 A request with imem_valid=0 SHALL stall in FETCH indefinitely, with no other state change.
REQ-015 DECODE SHALL latch A=R[IR[19:16]], B=R[IR[3:0]], C=R[IR[11:8]], evaluate the condition IR[31:28] against NZCV, and classify the encoding.
REQ-016 Encoding classes SHALL be DP0 (IR[27:25]=000, IR[4]=0), DP1 (000, IR[7]=0, IR[4]=1) and DP2 (001); any other encoding SHALL pulse illegal for one cycle and return to FETCH.
REQ-017 Supported conditions SHALL be EQ,NE,CS,CC,MI,PL,VS,VC (0000-0111) and AL (1110); any other condition, or a failed condition, SHALL skip to FETCH with no register or flag change.
REQ-018 Shifter operand for DP0 SHALL be B shifted by imm5 = IR[11:7].
REQ-019 Shifter operand for DP1 SHALL be B shifted by C[7:0].
REQ-020 Shifter operand for DP2 SHALL be zero-extended imm8 = IR[7:0] rotated right by 2*IR[11:8].
REQ-021 Shift type SHALL come from IR[6:5] (LSL, LSR, ASR, ROR) for DP0/DP1.
REQ-022 A shift amount of 0 SHALL pass the operand through with shifter carry = NZCV.C.
REQ-023 Shift amounts >= DATA_W SHALL follow: LSL/LSR give 0, ASR gives sign fill, ROR uses amount mod DATA_W.
REQ-024 EXEC SHALL compute F for IR[24:21] = AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN, all in DATA_W-bit arithmetic.
REQ-025 Flags for arithmetic ops SHALL take C and V from the ALU.
REQ-026 Flags for logical ops SHALL take C from the shifter carry and leave V unchanged.
REQ-027 N SHALL equal F[DATA_W-1] and Z SHALL equal (F==0).
REQ-028 WB SHALL write F to R[IR[15:12]] with Write_Reg=1 for all ops except TST/TEQ/CMP/CMN, which SHALL never write a register.
REQ-029 NZCV SHALL update in WB only when S=IR[20]=1.
REQ-030 WB SHALL pulse retire for one cycle.
REQ-031 R15 SHALL be an ordinary register with no PC alias.
REQ-032 Latency SHALL be 4 cycles per executed instruction when imem_valid returns in the request cycle.

Reset
REQ-033 rst SHALL put state=FETCH, PC=RST_PC, IR=0, NZCV=0, A=B=C=F=0, all 16 registers=0 and all strobes=0.
REQ-034 rst SHALL win over every other event, including mid-instruction and coincident imem_valid; the instruction in flight SHALL be discarded.

Structure
REQ-035 A shared package SHALL hold the state enum, ALU opcode constants, shift-type constants, condition codes and encoding-class constants.
REQ-036 A combinational decoder sub-module, cpu_dp_decode, SHALL produce the class, ALU op, shift op, operand selects, write-enable and condition-pass signals.

Verification
REQ-037 After reset, MOV R1,#0xFF (E3A010FF) SHALL give R1=0x000000FF, PC=1 and retire asserted at cycle 4.
REQ-038 R1=0xFFFFFFFF, ADDS R2,R1,#1 SHALL give R2=0 and NZCV=0110.
REQ-039 Executing CMP then MOVEQ/MOVNE SHALL execute only the matching instruction.
REQ-040 Holding imem_valid=0 for 5 cycles SHALL stall the core in FETCH with all state unchanged.
REQ-041 R3=0x80000000, MOVS R4,R3,ASR R5 with R5=40 SHALL give R4=0xFFFFFFFF and C=1.
REQ-042 Fetching 0xE6000010 SHALL pulse illegal with no register change, and asserting rst during EXEC SHALL return PC=RST_PC and all registers to 0.
